// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-way round-robin arbiter with registered one-hot grant
// Optional hold-timeout preemption is built when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 2..256");
  end

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic       to_d;

  logic       grant_valid_q, grant_valid_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic [7:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       expire;

  // Scan offsets high to low so the nearest set bit at or above ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);

  logic [CW-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = '0;
    if (state_q == GRANT) hold_d = hold_q + 1'b1;
  end

  assign expire = (hold_q == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d = GRANT;
          idx_d   = win_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // A request dropping on the expiry edge counts as a normal release.
        if (!req[idx_q]) begin
          state_d = GAP;
          ptr_d   = idx_q + 3'd1;
        end else if (expire) begin
          state_d = GAP;
          ptr_d   = idx_q + 3'd1;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_valid_d = (state_d == GRANT);
    grant_idx_d   = grant_valid_d ? idx_d : 3'd0;
    grant_d       = grant_valid_d ? (8'h01 << idx_d) : 8'h00;
    busy_d        = (state_d != IDLE);
    timeout_d     = to_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_valid_q <= 1'b0;
      grant_idx_q   <= 3'd0;
      grant_q       <= 8'h00;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - randomized and directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant       (grant),
    .busy        (busy),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Reference: who holds the grant, where the search starts, and tenure length.
  logic m_valid = 1'b0;
  int   m_idx   = 0;
  int   m_ptr   = 0;
  int   m_hold  = 0;
  logic m_gap   = 1'b0;
  logic m_to    = 1'b0;

`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  function automatic int rr_pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_ptr   <= 0;
      m_hold  <= 0;
      m_gap   <= 1'b0;
      m_to    <= 1'b0;
    end else if (m_valid) begin
      if (!req[m_idx]) begin
        m_valid <= 1'b0;
        m_ptr   <= (m_idx + 1) % 8;
        m_gap   <= 1'b1;
        m_to    <= 1'b0;
      end else if (TO_EN && m_hold == MAX_HOLD - 1) begin
        m_valid <= 1'b0;
        m_ptr   <= (m_idx + 1) % 8;
        m_gap   <= 1'b1;
        m_to    <= 1'b1;
      end else begin
        m_hold  <= m_hold + 1;
        m_to    <= 1'b0;
      end
    end else begin
      m_gap <= 1'b0;
      m_to  <= 1'b0;
      if (rr_pick(req, m_ptr) >= 0) begin
        m_valid <= 1'b1;
        m_idx   <= rr_pick(req, m_ptr);
        m_hold  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (grant_valid !== m_valid ||
        grant_idx   !== (m_valid ? 3'(m_idx) : 3'd0) ||
        grant       !== (m_valid ? (8'h01 << m_idx) : 8'h00) ||
        busy        !== (m_valid || m_gap) ||
        timeout     !== m_to) begin
      errors++;
      $display("FAIL model t=%0t got v=%0b idx=%0d g=%02h busy=%0b to=%0b exp v=%0b idx=%0d busy=%0b to=%0b",
               $time, grant_valid, grant_idx, grant, busy, timeout,
               m_valid, m_valid ? m_idx : 0, m_valid || m_gap, m_to);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h exp %02h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values with all requests asserted.
    rst_n = 1'b0;
    req   = 8'hFF;
    tick();
    chk("rst_grant", grant, 8'h00);
    chk("rst_idx", 8'(grant_idx), 8'h00);
    chk("rst_valid", 8'(grant_valid), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_timeout", 8'(timeout), 8'h00);
    rst_n = 1'b1;
    req   = 8'h01;
    tick();
    chk("first_grant", grant, 8'h01);
    chk("first_idx", 8'(grant_idx), 8'h00);
    chk("first_valid", 8'(grant_valid), 8'h01);

    // Rotation: each grantee drops for one cycle then re-asserts.
    do_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      chk("rot_idx", 8'(grant_idx), 8'(k % 8));
      chk("rot_grant", grant, 8'h01 << (k % 8));
      req = 8'hFF & ~(8'h01 << (k % 8));
      tick();
      chk("rot_gap_valid", 8'(grant_valid), 8'h00);
      chk("rot_gap_busy", 8'(busy), 8'h01);
      req = 8'hFF;
      tick();
    end

    // Wrap and priority.
    do_reset();
    req = 8'h40;
    tick();
    chk("wrap_g6", grant, 8'h40);
    req = 8'h01;
    tick();
    chk("wrap_gap", 8'(grant_valid), 8'h00);
    req = 8'h41;
    tick();
    chk("wrap_g0", grant, 8'h01);
    req = 8'h40;
    tick();
    chk("wrap_gap2", 8'(grant_valid), 8'h00);
    req = 8'h41;
    tick();
    chk("wrap_g6b", grant, 8'h40);

    // Hold grant 3 while other bits toggle.
    do_reset();
    req = 8'h08;
    tick();
    for (int k = 0; k < 20; k++) begin
      chk("hold_g3", grant, 8'h08);
      req = 8'($urandom) | 8'h08;
      tick();
    end
    chk("hold_g3_end", grant, 8'h08);
    req = 8'h31;
    tick();
    chk("hold_release", grant, 8'h00);
    tick();
    chk("hold_next", grant, 8'h10);

    // Constant requests from 0 and 1.
    do_reset();
    req = 8'h03;
`ifdef RR_ARB_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < MAX_HOLD; k++) begin
        tick();
        chk("to_grant", grant, (r == 0) ? 8'h01 : 8'h02);
        chk("to_quiet", 8'(timeout), 8'h00);
      end
      tick();
      chk("to_pulse", 8'(timeout), 8'h01);
      chk("to_gap", 8'(grant_valid), 8'h00);
    end
    tick();
    chk("to_back0", grant, 8'h01);
`else
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("nto_grant", grant, 8'h01);
      chk("nto_timeout", 8'(timeout), 8'h00);
    end
`endif

    // Asynchronous reset in the middle of a tenure.
    do_reset();
    req = 8'h20;
    tick();
    tick();
    chk("mid_g5", grant, 8'h20);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_async_grant", grant, 8'h00);
    chk("mid_async_busy", 8'(busy), 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_after_g5", grant, 8'h20);

    // Random traffic with sticky requests and occasional async resets.
    for (int n = 0; n < 600; n++) begin
      req = req ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
